// File: rtl/rr_burst_pkg.sv
// Shared types and constants for the round-robin burst arbiter.
package rr_burst_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_MAX_BURST = 8;

  // One extra bit so the counter can hold MAX_BURST itself.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational rotating-priority picker: lowest requester at or after ptr+1 wins.
module rr_pick
  import rr_burst_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [IW-1:0]        start;
  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl;

  always_comb begin
    start = (ptr == IW'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;
    mask  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= 32'(start));
    end
    // Lower half covers start..N-1, upper half wraps around to 0..N-1.
    dbl   = {req, req & mask};
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx   = IW'(i % NUM_REQ);
      end
    end
    gnt = '0;
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter sharing one valid/ready stream among NUM_REQ requesters.
// Optional per-requester burst weights when RR_BURST_WEIGHT_EN is defined.
module rr_burst_arbiter
  import rr_burst_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter  int unsigned DW        = DEF_DW,
  parameter  int unsigned MAX_BURST = DEF_MAX_BURST,
  localparam int unsigned IW        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
`ifdef RR_BURST_WEIGHT_EN
  input  logic [NUM_REQ*8-1:0]  req_weight,
`endif
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic                  o_vld,
  output logic [DW-1:0]         o_data,
  output logic                  o_last,
  output logic [IW-1:0]         o_src,
  input  logic                  i_rdy,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  busy
);

  localparam int unsigned CW = cnt_width(MAX_BURST);

  state_e             state, state_nxt;
  logic [IW-1:0]      ptr;
  logic [CW-1:0]      beat_cnt;
  logic [CW-1:0]      cap_m1;
  logic [CW-1:0]      grant_cap_m1;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               start_grant;
  logic               fire;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_vld),
    .ptr   (ptr),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .found (win_found)
  );

`ifdef RR_BURST_WEIGHT_EN
  logic [7:0] win_weight;
  always_comb begin
    win_weight = req_weight[32'(win_idx)*8 +: 8];
    if (win_weight == 8'd0 || 32'(win_weight) > MAX_BURST)
      grant_cap_m1 = CW'(MAX_BURST - 1);
    else
      grant_cap_m1 = CW'(win_weight - 8'd1);
  end
`else
  assign grant_cap_m1 = CW'(MAX_BURST - 1);
`endif

  assign start_grant = (state == ARB) && en && win_found;
  assign fire        = o_vld && i_rdy;
  assign busy        = (state == XFER);

  always_comb begin
    o_vld   = (state == XFER) && req_vld[o_src];
    o_data  = req_data[32'(o_src)*DW +: DW];
    o_last  = (state == XFER) && (req_last[o_src] || (beat_cnt == cap_m1));
    req_rdy = '0;
    if (state == XFER) req_rdy[o_src] = i_rdy;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:     if (start_grant)     state_nxt = XFER;
      XFER:    if (fire && o_last)  state_nxt = ARB;
      default:                      state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ARB;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= IW'(NUM_REQ - 1);
      o_src    <= '0;
      o_grant  <= '0;
      beat_cnt <= '0;
      cap_m1   <= CW'(MAX_BURST - 1);
    end else if (start_grant) begin
      o_grant  <= win_gnt;
      o_src    <= win_idx;
      ptr      <= win_idx;
      beat_cnt <= '0;
      cap_m1   <= grant_cap_m1;
    end else if (fire) begin
      if (o_last) o_grant  <= '0;
      else        beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Shares one downstream valid/ready stream port between NUM_REQ requesters using round-robin arbitration. A grant is held for a whole burst, up to MAX_BURST beats. The block sits in front of a single shared resource, such as a memory write port or a bus master. It multiplexes the granted requester's beats onto the output and returns backpressure only to that requester.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DW, 32, beat data width
- MAX_BURST, 8, maximum beats per grant (1..256)
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  arbitration enable; gates new grants only
- req_vld  in  NUM_REQ  requester i has a beat available
- req_data  in  NUM_REQ*DW  beat data, requester i at bits [i*DW +: DW]
- req_last  in  NUM_REQ  beat is the last of requester i's packet
- req_rdy  out  NUM_REQ  beat of requester i accepted this cycle
- o_vld  out  1  output beat valid
- o_data  out  DW  output beat data
- o_last  out  1  end of grant (packet last or burst cap reached)
- o_src  out  clog2(NUM_REQ)  index of granted requester
- i_rdy  in  1  downstream ready
- o_grant  out  NUM_REQ  registered one-hot grant, all-zero when idle
- busy  out  1  grant held

## Operation
- FSM has 2 states.
  - ARB: no grant.
    - If en=1 and req_vld≠0, pick a winner by rotating priority, starting at (ptr+1) mod NUM_REQ.
    - Register o_grant, o_src and ptr←winner, clear beat_cnt, go to XFER.
  - XFER: grant held.
    - o_vld = req_vld[src], o_data = req_data[src], req_rdy[src] = i_rdy. All other req_rdy are 0.
    - A beat fires when o_vld & i_rdy.
    - o_last = req_last[src] | (beat_cnt == MAX_BURST-1).
    - A fired beat with o_last=1 clears o_grant and returns the FSM to ARB. Otherwise beat_cnt increments.
- Burst cap:
  - Reaching the cap releases the grant even without req_last.
  - The requester continues its packet in a later grant.
- req_vld deasserting mid-burst:
  - The grant is held; o_vld=0 and beat_cnt holds.
  - There is no timeout.
- en=0 in XFER does not abort the burst. It only blocks the next grant.
- beat_cnt width is clog2(MAX_BURST)+1. beat_cnt never wraps, because it saturates into release.

## Timing
- Reset values:
  - FSM=ARB, ptr=NUM_REQ-1 (requester 0 highest priority first), beat_cnt=0.
  - o_grant=0, o_src=0, busy=0, o_vld=0, o_last=0, req_rdy=0.
  - o_data follows the mux of requester 0 but is don't-care while o_vld=0.
- Arbitration latency:
  - A request visible in ARB at edge k gets o_grant from edge k+1.
  - The first beat can fire in the cycle after edge k+1.
- One idle bubble cycle (ARB) follows every release. No back-to-back grants.
- Outputs o_vld, o_data, o_last and req_rdy are combinational from registered grant state plus inputs. No new register stage exists on the data path.
- Simultaneous requests resolve in the same cycle by rotating priority only.
- Reset asserted mid-burst aborts immediately: all outputs return to reset values, and the in-flight beat is not accepted.

## Configuration
- RR_BURST_WEIGHT_EN defined:
  - Adds input req_weight, width NUM_REQ*8.
  - The burst cap for requester i becomes req_weight[i*8 +: 8].
  - A value of 0, or any value above MAX_BURST, uses MAX_BURST.
  - The weight is sampled at grant time and held for that grant.
- Undefined: the port is absent and every requester uses MAX_BURST.

## Structure
- Package rr_burst_pkg:
  - State enum (ARB, XFER).
  - A function for beat counter width.
  - Default parameter constants.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and ptr.
  - Outputs: winner one-hot and index, plus a found flag.
  - Implemented as a double-width masked priority encode.
- Top level holds the FSM, ptr, beat_cnt, grant registers and output mux.

## Test plan
- Reset then req_vld=4'b1111, i_rdy=1, all req_last on beat 0.
  - Grants go 0,1,2,3,0 in order, one bubble cycle between grants, o_src matches.
- req_vld=4'b0100, 20-beat packet, MAX_BURST=8, i_rdy=1.
  - Three grants of 8, 8 and 4 beats.
  - o_last asserts on beats 8, 16 and 20; ptr stays on 2.
- Grant to requester 1 with i_rdy toggling 1/0 each cycle, packet of 3 beats.
  - Only 3 beats fire, req_rdy[1] follows i_rdy, and req_rdy of all other requesters stays 0.
- en=0 asserted on the 2nd beat of a 4-beat burst from requester 3.
  - The burst completes all 4 beats, then no grant is issued while en=0.
  - Requester 0 is granted 1 cycle after en returns to 1.
- rstn pulsed low during beat 5 of a burst.
  - Outputs go to reset values asynchronously.
  - After release with req_vld=4'b1010, requester 1 wins first.
- With RR_BURST_WEIGHT_EN: req_weight={8'd0,8'd2,8'd1,8'd3}, all requesting long packets.
  - Bursts of 3,1,2,8 beats for requesters 0,1,2,3.
